elixirchip_es1_spu_op_sub: RTL and testbench

Pipelined SPU subtract-with-borrow primitive, the inverse counterpart of the SPU add op: computes s_data0 − s_data1 − borrow using carry-as-not-borrow semantics, so that chained words and overflow detection work identically to the adder. It sits in the SPU datapath alongside the other es1 ops, driven by the same cke/clear/valid control, and its outputs feed the next op or the next word of a multi-word chain.

---
 rtl/elixirchip_es1_spu_pkg.sv | 20 ++
 rtl/elixirchip_es1_spu_delay.sv | 40 ++++
 rtl/elixirchip_es1_spu_op_sub.sv | 121 ++++++++++++
 tb/tb_elixirchip_es1_spu_op_sub.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the es1 SPU arithmetic ops: result tag bundle and
// the legal pipeline depth range common to the add and subtract ops.
package elixirchip_es1_spu_pkg;

    localparam int SPU_LATENCY_MIN = 1;
    localparam int SPU_LATENCY_MAX = 4;

    // Flags that travel down the pipeline alongside the data word.
    typedef struct packed {
        logic carry;
        logic msb_c;
        logic clear;
        logic valid;
    } spu_tag_t;

    function automatic bit spu_latency_ok(input int latency);
        return (latency >= SPU_LATENCY_MIN) && (latency <= SPU_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// Generic cke-gated delay line; LATENCY=0 degenerates to a plain wire.
module elixirchip_es1_spu_delay
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int  LATENCY     = 1,
    parameter type T           = logic,
    parameter T    RESET_VALUE = T'('0)
) (
    input  logic clk,
    input  logic reset,
    input  logic cke,
    input  T     s_data,
    output T     m_data
);

    if (LATENCY == 0) begin : g_wire
        assign m_data = s_data;
    end else begin : g_regs
        T dly_r [LATENCY];

        // Shift register, frozen entirely while cke is low.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < LATENCY; i++) begin
                    dly_r[i] <= RESET_VALUE;
                end
            end else if (cke) begin
                dly_r[0] <= s_data;
                for (int i = 1; i < LATENCY; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end else begin
                dly_r <= dly_r;
            end
        end

        assign m_data = dly_r[LATENCY-1];
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_sub.sv
// SPU subtract-with-borrow: s_data0 - s_data1 - !s_carry, carry meaning
// "no borrow" so multi-word chains and overflow match the add op.
module elixirchip_es1_spu_op_sub
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY         = 1,
    parameter int    DATA_BITS       = 8,
    parameter type   data_t          = logic [DATA_BITS-1:0],
    parameter data_t CLEAR_DATA      = 'x,
    parameter logic  CLEAR_CARRY     = 1'bx,
    parameter logic  CLEAR_MSB_C     = 1'bx,
    parameter bit    IMMEDIATE_CARRY = 1'b1,
    parameter bit    IMMEDIATE_DATA0 = 1'b0,
    parameter bit    IMMEDIATE_DATA1 = 1'b0,
    parameter bit    USE_CLEAR       = 1'b1,
    parameter bit    USE_VALID       = 1'b1,
    parameter string DEVICE          = "RTL",
    parameter string SIMULATION      = "false",
    parameter string DEBUG           = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  logic  s_carry,
    input  data_t s_data0,
    input  data_t s_data1,
    input  logic  s_clear,
    input  logic  s_valid,
    output data_t m_data,
    output logic  m_carry,
    output logic  m_msb_c
);

    typedef struct packed {
        data_t    data;
        spu_tag_t tag;
    } bundle_t;

    logic [DATA_BITS:0] sum_s;
    bundle_t            in_s;
    bundle_t            pre_out_s;
    data_t              m_data_r;
    logic               m_carry_r;
    logic               m_msb_c_r;

    if (!spu_latency_ok(LATENCY)) begin : g_latency_check
        $error("elixirchip_es1_spu_op_sub: LATENCY out of range");
    end

    // Static-input folding and the device/debug strings never alter the datapath.
    if (IMMEDIATE_CARRY || IMMEDIATE_DATA0 || IMMEDIATE_DATA1) begin : g_static_inputs
    end
    if ((DEVICE != "") || (SIMULATION == "true") || (DEBUG == "true")) begin : g_config_info
    end

    // Subtract by adding the inverted subtrahend; carry into the MSB is
    // recovered from the MSB sum bit, which also covers DATA_BITS == 1.
    always_comb begin
        sum_s = {1'b0, s_data0} + {1'b0, ~s_data1} + {{DATA_BITS{1'b0}}, s_carry};
        in_s.data      = sum_s[DATA_BITS-1:0];
        in_s.tag.carry = sum_s[DATA_BITS];
        in_s.tag.msb_c = sum_s[DATA_BITS-1] ^ s_data0[DATA_BITS-1] ^ ~s_data1[DATA_BITS-1];
        in_s.tag.clear = s_clear;
        in_s.tag.valid = s_valid;
    end

    if (LATENCY == 1) begin : g_lat1
        assign pre_out_s = in_s;
    end else begin : g_latn
        bundle_t st1_r;

        // Stage 1: capture the full result bundle with its clear/valid tags.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st1_r <= '0;
            end else if (cke) begin
                st1_r <= in_s;
            end else begin
                st1_r <= st1_r;
            end
        end

        elixirchip_es1_spu_delay #(
            .LATENCY     (LATENCY - 2),
            .T           (bundle_t),
            .RESET_VALUE (bundle_t'('0))
        ) u_delay (
            .clk    (clk),
            .reset  (reset),
            .cke    (cke),
            .s_data (st1_r),
            .m_data (pre_out_s)
        );
    end

    // Output stage: clear outranks valid; an untagged sample leaves outputs held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data_r  <= '0;
            m_carry_r <= 1'b0;
            m_msb_c_r <= 1'b0;
        end else if (cke && USE_CLEAR && pre_out_s.tag.clear) begin
            m_data_r  <= CLEAR_DATA;
            m_carry_r <= CLEAR_CARRY;
            m_msb_c_r <= CLEAR_MSB_C;
        end else if (cke && (!USE_VALID || pre_out_s.tag.valid)) begin
            m_data_r  <= pre_out_s.data;
            m_carry_r <= pre_out_s.tag.carry;
            m_msb_c_r <= pre_out_s.tag.msb_c;
        end else begin
            m_data_r  <= m_data_r;
            m_carry_r <= m_carry_r;
            m_msb_c_r <= m_msb_c_r;
        end
    end

    assign m_data  = m_data_r;
    assign m_carry = m_carry_r;
    assign m_msb_c = m_msb_c_r;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sub.sv
// Randomised bench for the SPU subtract op: three configurations share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_elixirchip_es1_spu_op_sub;

    localparam logic [7:0] CLR_D = 8'hAA;
    localparam logic       CLR_C = 1'b1;
    localparam logic       CLR_M = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cke = 1'b0;
    logic       s_carry = 1'b0;
    logic [7:0] s_data0 = 8'h00;
    logic [7:0] s_data1 = 8'h00;
    logic       s_clear = 1'b0;
    logic       s_valid = 1'b0;

    logic [7:0] a_data, b_data, c_data;
    logic       a_carry, b_carry, c_carry;
    logic       a_msb, b_msb, c_msb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_sub #(.LATENCY(1), .DATA_BITS(8), .CLEAR_DATA(CLR_D),
        .CLEAR_CARRY(CLR_C), .CLEAR_MSB_C(CLR_M)) dut_a (
        .clk(clk), .reset(reset), .cke(cke), .s_carry(s_carry), .s_data0(s_data0),
        .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
        .m_data(a_data), .m_carry(a_carry), .m_msb_c(a_msb));

    elixirchip_es1_spu_op_sub #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(CLR_D),
        .CLEAR_CARRY(CLR_C), .CLEAR_MSB_C(CLR_M)) dut_b (
        .clk(clk), .reset(reset), .cke(cke), .s_carry(s_carry), .s_data0(s_data0),
        .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
        .m_data(b_data), .m_carry(b_carry), .m_msb_c(b_msb));

    elixirchip_es1_spu_op_sub #(.LATENCY(2), .DATA_BITS(8), .CLEAR_DATA(8'h55),
        .CLEAR_CARRY(1'b0), .CLEAR_MSB_C(1'b1), .USE_CLEAR(1'b0), .USE_VALID(1'b0)) dut_c (
        .clk(clk), .reset(reset), .cke(cke), .s_carry(s_carry), .s_data0(s_data0),
        .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
        .m_data(c_data), .m_carry(c_carry), .m_msb_c(c_msb));

    logic [7:0] got_d [3];
    logic       got_c [3];
    logic       got_m [3];
    assign got_d[0] = a_data;  assign got_c[0] = a_carry; assign got_m[0] = a_msb;
    assign got_d[1] = b_data;  assign got_c[1] = b_carry; assign got_m[1] = b_msb;
    assign got_d[2] = c_data;  assign got_c[2] = c_carry; assign got_m[2] = c_msb;

    // Reference model: per-configuration sample queue of depth LATENCY-1.
    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       m;
        logic       clr;
        logic       vld;
    } smp_t;

    smp_t       qa[$], qb[$], qc[$];
    logic [7:0] exp_d [3];
    logic       exp_c [3];
    logic       exp_m [3];

    function automatic smp_t ref_sub(input logic [7:0] a, input logic [7:0] b,
                                     input logic cin, input logic clr, input logic vld);
        smp_t r;
        int   bin = cin ? 0 : 1;
        int   diff = int'(a) - int'(b) - bin;
        int   sa = $signed(a);
        int   sb = $signed(b);
        int   sd = sa - sb - bin;
        logic ov = (sd < -128) || (sd > 127);
        r.d = 8'(diff);
        r.c = (diff >= 0);
        r.m = r.c ^ ov;
        r.clr = clr;
        r.vld = vld;
        return r;
    endfunction

    function automatic smp_t zero_smp();
        smp_t z;
        z.d = 8'h00; z.c = 1'b0; z.m = 1'b0; z.clr = 1'b0; z.vld = 1'b0;
        return z;
    endfunction

    task automatic model_apply(input int i, input smp_t s);
        if ((i != 2) && s.clr) begin
            exp_d[i] = CLR_D; exp_c[i] = CLR_C; exp_m[i] = CLR_M;
        end else if ((i == 2) || s.vld) begin
            exp_d[i] = s.d; exp_c[i] = s.c; exp_m[i] = s.m;
        end
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); qc.delete();
        for (int k = 0; k < 2; k++) qb.push_back(zero_smp());
        qc.push_back(zero_smp());
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 8'h00; exp_c[i] = 1'b0; exp_m[i] = 1'b0;
        end
    endtask

    task automatic model_clock();
        smp_t s;
        if (cke) begin
            s = ref_sub(s_data0, s_data1, s_carry, s_clear, s_valid);
            qa.push_back(s); qb.push_back(s); qc.push_back(s);
            model_apply(0, qa.pop_front());
            model_apply(1, qb.pop_front());
            model_apply(2, qc.pop_front());
        end
    endtask

    task automatic step(input logic k, input logic c, input logic [7:0] a,
                        input logic [7:0] b, input logic clr, input logic vld);
        @(negedge clk);
        cke = k; s_carry = c; s_data0 = a; s_data1 = b; s_clear = clr; s_valid = vld;
        @(posedge clk);
        if (reset) model_clock();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        step(1'b1, 1'b1, 8'h50, 8'h30, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h50, 8'h30, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_d[i] !== 8'h00 || got_c[i] !== 1'b0 || got_m[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: got %h/%b/%b want 00/0/0", i, got_d[i], got_c[i], got_m[i]);
            end
        end
        @(negedge clk);
        cke = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] va [4] = '{8'h50, 8'h00, 8'h80, 8'h05};
        logic [7:0] vb [4] = '{8'h30, 8'h01, 8'h01, 8'h03};
        logic       vc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] wd [4] = '{8'h20, 8'hFF, 8'h7F, 8'h01};
        logic       wc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       wm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int v = 0; v < 4; v++) begin
            step(1'b1, vc[v], va[v], vb[v], 1'b0, 1'b1);
            total++;
            if (a_data !== wd[v] || a_carry !== wc[v] || a_msb !== wm[v]) begin
                bad++;
                $display("FAIL basic vec%0d: got %h/%b/%b want %h/%b/%b", v, a_data, a_carry, a_msb, wd[v], wc[v], wm[v]);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_m[i] !== exp_m[i]) begin
                    bad++;
                    $display("FAIL basic_model dut%0d: got %h/%b/%b want %h/%b/%b", i, got_d[i], got_c[i], got_m[i], exp_d[i], exp_c[i], exp_m[i]);
                end
            end
        end
    endtask

    task automatic test_cke_gating();
        logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int p = 0; p < 9; p++) begin
            step(pat[p], 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_m[i] !== exp_m[i]) begin
                    bad++;
                    $display("FAIL cke dut%0d step%0d: got %h/%b/%b want %h/%b/%b", i, p, got_d[i], got_c[i], got_m[i], exp_d[i], exp_c[i], exp_m[i]);
                end
            end
        end
    endtask

    task automatic test_clear_hold();
        step(1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1);
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_m[i] !== exp_m[i]) begin
                    bad++;
                    $display("FAIL clear dut%0d step%0d: got %h/%b/%b want %h/%b/%b", i, p, got_d[i], got_c[i], got_m[i], exp_d[i], exp_c[i], exp_m[i]);
                end
            end
        end
        total++;
        if (a_data !== CLR_D || b_data !== CLR_D || b_carry !== CLR_C || b_msb !== CLR_M) begin
            bad++;
            $display("FAIL clear_value: got a=%h b=%h/%b/%b want %h/%b/%b", a_data, b_data, b_carry, b_msb, CLR_D, CLR_C, CLR_M);
        end
    endtask

    task automatic test_reset_midstream();
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        cke = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_d[i] !== 8'h00 || got_c[i] !== 1'b0 || got_m[i] !== 1'b0) begin
                bad++;
                $display("FAIL async_reset dut%0d: got %h/%b/%b want 00/0/0", i, got_d[i], got_c[i], got_m[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_m[i] !== exp_m[i]) begin
                    bad++;
                    $display("FAIL post_reset dut%0d step%0d: got %h/%b/%b want %h/%b/%b", i, p, got_d[i], got_c[i], got_m[i], exp_d[i], exp_c[i], exp_m[i]);
                end
            end
        end
        total++;
        if (b_data !== 8'h00 || b_carry !== 1'b0) begin
            bad++;
            $display("FAIL stale_sample: got %h/%b want 00/0", b_data, b_carry);
        end
    endtask

    task automatic test_no_valid_no_clear();
        for (int p = 0; p < 2; p++) begin
            step(1'b1, 1'b1, 8'h10, 8'h01, 1'b1, 1'b0);
        end
        total++;
        if (c_data !== 8'h0F || c_carry !== 1'b1 || c_msb !== 1'b1) begin
            bad++;
            $display("FAIL novalid: got %h/%b/%b want 0f/1/1", c_data, c_carry, c_msb);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_m[i] !== exp_m[i]) begin
                bad++;
                $display("FAIL novalid_model dut%0d: got %h/%b/%b want %h/%b/%b", i, got_d[i], got_c[i], got_m[i], exp_d[i], exp_c[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 300; p++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_m[i] !== exp_m[i]) begin
                    bad++;
                    $display("FAIL random dut%0d step%0d: got %h/%b/%b want %h/%b/%b", i, p, got_d[i], got_c[i], got_m[i], exp_d[i], exp_c[i], exp_m[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cke_gating();
        test_clear_hold();
        test_reset_midstream();
        test_no_valid_no_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
